// File: rtl/xm_wb_mem_ctrl.sv
// ============================================================================
// Module      : xm_wb_mem_ctrl
// Description : Bridges the xm datapath single-request memory port to a
//               Wishbone-classic master bus. It supports byte-lane steering,
//               read-data alignment, bus-error reporting and a
//               misaligned-word trap.
//               The optional bus-hang watchdog is enabled by defining
//               XM_MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xm_wb_mem_ctrl #(
    parameter int WORD    = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // datapath request side
    input  logic              en_i,
    input  logic              rw_i,
    input  logic              byte_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD-1:0]   data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [WORD-1:0]   data_o,
    // Wishbone master side
    input  logic              ack_i,
    input  logic              err_i,
    input  logic [WORD-1:0]   dat_i,
    output logic              we_o,
    output logic              stb_o,
    output logic              cyc_o,
    output logic [WORD/8-1:0] sel_o,
    output logic [ADDR_W-$clog2(WORD/8)-1:0] adr_o,
    output logic [WORD-1:0]   dat_o
);

    localparam int SEL_W = WORD / 8;
    localparam int LSB   = $clog2(WORD / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [ADDR_W-LSB-1:0] adr_q, adr_d;
    logic [WORD-1:0]       wdat_q, wdat_d;
    logic [WORD-1:0]       rdat_q, rdat_d;
    logic                  byte_q, byte_d;
    logic [LSB-1:0]        lane_q, lane_d;
    logic                  fail_q, fail_d;
`ifdef XM_MEM_TIMEOUT_EN
    logic [7:0]            cnt_q, cnt_d;
`endif

    // Next-state and bus-output computation for the request FSM
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        byte_d  = byte_q;
        lane_d  = lane_q;
        fail_d  = fail_q;
`ifdef XM_MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    byte_d = byte_i;
                    lane_d = addr_i[LSB-1:0];
                    if (!byte_i && (addr_i[LSB-1:0] != '0)) begin
                        // misaligned word: trap without touching the bus
                        state_d = S_RESP;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = S_BUS;
                        fail_d  = 1'b0;
                        cyc_d   = 1'b1;
                        we_d    = rw_i;
                        adr_d   = addr_i[ADDR_W-1:LSB];
                        sel_d   = byte_i ? (SEL_W'(1) << addr_i[LSB-1:0]) : '1;
                        wdat_d  = byte_i ? {SEL_W{data_i[7:0]}} : data_i;
`ifdef XM_MEM_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end
                end
            end
            S_BUS: begin
`ifdef XM_MEM_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (err_i) begin
                    // error wins over a simultaneous ack; read data is not taken
                    state_d = S_RESP;
                    fail_d  = 1'b1;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                end else if (ack_i) begin
                    state_d = S_RESP;
                    fail_d  = 1'b0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    if (!we_q) begin
                        rdat_d = byte_q ? WORD'(dat_i[{lane_q, 3'b000} +: 8]) : dat_i;
                    end
                end
`ifdef XM_MEM_TIMEOUT_EN
                else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                    // watchdog: abandon a slave that never answers
                    state_d = S_RESP;
                    fail_d  = 1'b1;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
                fail_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                sel_d   = '0;
                fail_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            byte_q  <= 1'b0;
            lane_q  <= '0;
            fail_q  <= 1'b0;
`ifdef XM_MEM_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            byte_q  <= byte_d;
            lane_q  <= lane_d;
            fail_q  <= fail_d;
`ifdef XM_MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_RESP);
    assign err_o  = (state_q == S_RESP) && fail_q;
    assign data_o = rdat_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = cyc_q;
    assign we_o   = we_q;
    assign sel_o  = sel_q;
    assign adr_o  = adr_q;
    assign dat_o  = wdat_q;

endmodule

`default_nettype wire
